// File: rtl/rom_arb_pkg.sv
// Shared types and width helpers for the ROM port arbiter.
package rom_arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HANDOFF = 2'd2
  } arb_state_e;

  // Smallest w with 2**w >= n.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  function automatic int owner_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rom_port_arbiter_rr_pick.sv
// Combinational requester picker: rotate from rr_ptr and take the first set bit.
// With ROM_ARB_FIXED_PRIO_EN defined it becomes lowest-index-wins and ignores rr_ptr.
module rr_pick
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   rr_ptr,
  output logic               found,
  output logic [OWN_W-1:0]   winner
);

`ifdef ROM_ARB_FIXED_PRIO_EN
  // Lowest set index wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      winner = (req[k] && !found) ? OWN_W'(k) : winner;
      found  = found | req[k];
    end
  end
`else
  logic [OWN_W:0]   sum_s;
  logic [OWN_W:0]   wrap_s;
  logic [OWN_W-1:0] cand_s;

  // Scan candidates rr_ptr, rr_ptr+1, ... modulo NUM_REQ; first hit wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum_s  = '0;
    wrap_s = '0;
    cand_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s  = {1'b0, rr_ptr} + (OWN_W+1)'(k);
      wrap_s = (sum_s >= (OWN_W+1)'(NUM_REQ)) ? (sum_s - (OWN_W+1)'(NUM_REQ)) : sum_s;
      cand_s = wrap_s[OWN_W-1:0];
      winner = (req[cand_s] && !found) ? cand_s : winner;
      found  = found | req[cand_s];
    end
  end
`endif

endmodule

// File: rtl/rom_port_arbiter.sv
// Burst-holding arbiter sharing one single-port ROM among NUM_REQ cost engines.
// Define ROM_ARB_FIXED_PRIO_EN for fixed priority (lowest index) instead of round-robin.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int ROM_LAT   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         rd_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_en,
  input  logic [DATA_W-1:0]         rom_data
);

  localparam int OWN_W = owner_w(NUM_REQ);
  localparam int CNT_W = clog2(MAX_BURST + 1);

  arb_state_e         state_r, state_s;
  logic [OWN_W-1:0]   owner_r, owner_s;
  logic [OWN_W-1:0]   rr_ptr_r, rr_ptr_s;
  logic [OWN_W-1:0]   ptr_next_s;
  logic [OWN_W-1:0]   pick_idx_s;
  logic               pick_found_s;
  logic [CNT_W-1:0]   burst_cnt_r, burst_cnt_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic               read_s;
  logic               burst_full_s;
  logic               other_pend_s;
  // Return tag carried as a one-hot owner vector; all-zero means no read.
  logic [NUM_REQ-1:0] tag_pipe_r [ROM_LAT];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .found  (pick_found_s),
    .winner (pick_idx_s)
  );

  assign read_s       = (state_r == GRANT) && req[owner_r];
  assign rom_en       = read_s;
  assign cnt_inc_s    = (burst_cnt_r == CNT_W'(MAX_BURST)) ? burst_cnt_r : (burst_cnt_r + CNT_W'(1));
  assign burst_full_s = read_s && (cnt_inc_s == CNT_W'(MAX_BURST));
  assign ptr_next_s   = (owner_r == OWN_W'(NUM_REQ - 1)) ? '0 : (owner_r + OWN_W'(1));
  assign rd_valid     = tag_pipe_r[ROM_LAT-1];
  assign rd_data      = rom_data;

  // ROM address follows the owner's request address while granted.
  always_comb begin
    rom_addr = '0;
    if (state_r == GRANT) begin
      rom_addr = req_addr[int'(owner_r)*ADDR_W +: ADDR_W];
    end else begin
      rom_addr = '0;
    end
  end

  // Competing requests that may force a burst-limit handoff.
  always_comb begin
    other_pend_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      other_pend_s = other_pend_s | (req[k] & (k < int'(owner_r)));
`else
      other_pend_s = other_pend_s | (req[k] & (k != int'(owner_r)));
`endif
    end
  end

  // Next-state, owner, pointer and burst counter.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    rr_ptr_s    = rr_ptr_r;
    burst_cnt_s = burst_cnt_r;
    gnt_s       = gnt;
    case (state_r)
      IDLE, HANDOFF: begin
        if (pick_found_s) begin
          state_s     = GRANT;
          owner_s     = pick_idx_s;
          gnt_s       = NUM_REQ'(1'b1) << pick_idx_s;
          burst_cnt_s = '0;
        end else begin
          state_s = IDLE;
          gnt_s   = '0;
        end
      end
      GRANT: begin
        if (!req[owner_r]) begin
          state_s  = HANDOFF;
          gnt_s    = '0;
          rr_ptr_s = ptr_next_s;
        end else if (burst_full_s && other_pend_s) begin
          state_s     = HANDOFF;
          gnt_s       = '0;
          rr_ptr_s    = ptr_next_s;
          burst_cnt_s = cnt_inc_s;
        end else begin
          state_s     = GRANT;
          burst_cnt_s = cnt_inc_s;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = '0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      owner_r     <= '0;
      rr_ptr_r    <= '0;
      burst_cnt_r <= '0;
      gnt         <= '0;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      rr_ptr_r    <= rr_ptr_s;
      burst_cnt_r <= burst_cnt_s;
      gnt         <= gnt_s;
    end
  end

  // Owner tag pipeline aligned to the ROM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_pipe_r[i] <= '0;
      end
    end else begin
      tag_pipe_r[0] <= read_s ? (NUM_REQ'(1'b1) << owner_r) : '0;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_pipe_r[i] <= tag_pipe_r[i-1];
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: per-cycle grant/read checks plus tagged return matching.
module tb_rom_port_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 16;
  localparam int ROM_LAT   = 2;

  typedef struct {
    int                own;
    logic [DATA_W-1:0] data;
    int                due;
  } sb_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         rd_data;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [ADDR_W-1:0]         rom_addr;
  logic                      rom_en;
  logic [DATA_W-1:0]         rom_data;

  logic [DATA_W-1:0] rom_q [ROM_LAT];
  logic [ADDR_W-1:0] addr_cnt [NUM_REQ];
  sb_t               sb_q [$];
  sb_t               mon_e;
  logic [NUM_REQ-1:0] mon_exp;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  rom_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MAX_BURST(MAX_BURST), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rd_data(rd_data), .rd_valid(rd_valid), .rom_addr(rom_addr),
    .rom_en(rom_en), .rom_data(rom_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    return DATA_W'(32'hC0DE_0000) ^ DATA_W'(a);
  endfunction

  // ROM macro model with ROM_LAT-cycle read latency.
  always @(posedge clk) begin
    rom_q[0] <= rom_en ? rom_fn(rom_addr) : '0;
    for (int i = 1; i < ROM_LAT; i++) rom_q[i] <= rom_q[i-1];
  end
  assign rom_data = rom_q[ROM_LAT-1];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Return monitor: every rd_valid must match the oldest outstanding read at its due cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      mon_e   = sb_q.pop_front();
      mon_exp = NUM_REQ'(1) << mon_e.own;
      check_eq("rd_valid", 64'(rd_valid), 64'(mon_exp));
      check_eq("rd_data", 64'(rd_data), 64'(mon_e.data));
    end else if (rd_valid != '0) begin
      check_eq("rd_valid_unexpected", 64'(rd_valid), 64'd0);
    end
  end

  // One cycle: drive req/addresses, check grant and read, record expected return.
  task automatic step(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] eg,
                      input logic een, input int eo);
    sb_t e;
    req = r;
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = addr_cnt[i];
    @(negedge clk);
    check_eq("gnt", 64'(gnt), 64'(eg));
    check_eq("rom_en", 64'(rom_en), 64'(een));
    if (een) begin
      check_eq("rom_addr", 64'(rom_addr), 64'(addr_cnt[eo]));
      e.own  = eo;
      e.data = rom_fn(addr_cnt[eo]);
      e.due  = cyc + ROM_LAT;
      sb_q.push_back(e);
      addr_cnt[eo] = addr_cnt[eo] + ADDR_W'(1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) addr_cnt[i] = ADDR_W'(i * 100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_gnt", 64'(gnt), 64'd0);
    check_eq("rst_rom_en", 64'(rom_en), 64'd0);
    check_eq("rst_rom_addr", 64'(rom_addr), 64'd0);
    check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Requesters 0 and 2 together at reset exit: 0 first, bubble, then 2.
    step(4'b0101, 4'b0000, 1'b0, 0);
    repeat (3) step(4'b0101, 4'b0001, 1'b1, 0);
    step(4'b0100, 4'b0001, 1'b0, 0);
    step(4'b0100, 4'b0000, 1'b0, 0);
    repeat (3) step(4'b0100, 4'b0100, 1'b1, 2);
    step(4'b0000, 4'b0100, 1'b0, 0);
    step(4'b0000, 4'b0000, 1'b0, 0);
    step(4'b0000, 4'b0000, 1'b0, 0);

    // Single short burst on requester 0, addresses 0..3.
    addr_cnt[0] = '0;
    step(4'b0001, 4'b0000, 1'b0, 0);
    repeat (4) step(4'b0001, 4'b0001, 1'b1, 0);
    step(4'b0000, 4'b0001, 1'b0, 0);
    step(4'b0000, 4'b0000, 1'b0, 0);
    step(4'b0000, 4'b0000, 1'b0, 0);

`ifdef ROM_ARB_FIXED_PRIO_EN
    // Fixed priority: 1 keeps the grant past the burst limit; 2 then 3 follow.
    step(4'b1110, 4'b0000, 1'b0, 0);
    repeat (20) step(4'b1110, 4'b0010, 1'b1, 1);
    step(4'b1100, 4'b0010, 1'b0, 0);
    step(4'b1100, 4'b0000, 1'b0, 0);
    repeat (3) step(4'b1100, 4'b0100, 1'b1, 2);
    step(4'b1000, 4'b0100, 1'b0, 0);
    step(4'b1000, 4'b0000, 1'b0, 0);
    repeat (2) step(4'b1000, 4'b1000, 1'b1, 3);
    step(4'b0000, 4'b1000, 1'b0, 0);
    step(4'b0000, 4'b0000, 1'b0, 0);
`else
    // Burst limit: 1 is cut after 16 reads because 3 is waiting, then resumes.
    step(4'b0010, 4'b0000, 1'b0, 0);
    for (int k = 1; k <= MAX_BURST; k++) step((k >= 5) ? 4'b1010 : 4'b0010, 4'b0010, 1'b1, 1);
    step(4'b1010, 4'b0000, 1'b0, 0);
    repeat (4) step(4'b1010, 4'b1000, 1'b1, 3);
    step(4'b0010, 4'b1000, 1'b0, 0);
    step(4'b0010, 4'b0000, 1'b0, 0);
    repeat (40 - MAX_BURST) step(4'b0010, 4'b0010, 1'b1, 1);
    step(4'b0000, 4'b0010, 1'b0, 0);
    step(4'b0000, 4'b0000, 1'b0, 0);
`endif

    // Uncontended 40-read burst: no bubble.
    step(4'b0100, 4'b0000, 1'b0, 0);
    repeat (40) step(4'b0100, 4'b0100, 1'b1, 2);
    step(4'b0000, 4'b0100, 1'b0, 0);
    step(4'b0000, 4'b0000, 1'b0, 0);
    step(4'b0000, 4'b0000, 1'b0, 0);

    // Reset mid-burst with two reads in flight.
    step(4'b0001, 4'b0000, 1'b0, 0);
    repeat (3) step(4'b0001, 4'b0001, 1'b1, 0);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_eq("mid_rst_gnt", 64'(gnt), 64'd0);
    check_eq("mid_rst_rom_en", 64'(rom_en), 64'd0);
    check_eq("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) step(4'b0000, 4'b0000, 1'b0, 0);

    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
